// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one 32-bit ALU through a round-robin grant
// and a single registered response stage with full-throughput handoff.
module alu (
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [3:0]  alu_control,
    output logic [31:0] result,
    output logic        zero
);
    always_comb begin
        result = alu_control == 4'b0000 ? src1 & src2 :
                 alu_control == 4'b0001 ? src1 | src2 :
                 alu_control == 4'b0010 ? src1 + src2 :
                 alu_control == 4'b0110 ? src1 - src2 :
                 alu_control == 4'b0111 ? {31'b0, $signed(src1) < $signed(src2)} :
                 alu_control == 4'b1100 ? ~(src1 | src2) : 32'b0;
        zero = result == 32'b0;
    end
endmodule

module alu_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [31:0] req0_src1,
    input  logic [31:0] req0_src2,
    input  logic [3:0]  req0_op,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_src1,
    input  logic [31:0] req1_src2,
    input  logic [3:0]  req1_op,
    output logic        req1_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        resp_zero,
    output logic        resp_id
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, state_nxt;
    logic last_grant, grant, can_accept, xfer, alu_zero;
    logic [31:0] alu_result;

    alu u_alu (
        .src1       (grant ? req1_src1 : req0_src1),
        .src2       (grant ? req1_src2 : req0_src2),
        .alu_control(grant ? req1_op : req0_op),
        .result     (alu_result),
        .zero       (alu_zero)
    );

    // rst_n gates the readies so nothing is offered while reset is held
    always_comb begin
        grant      = req0_valid && req1_valid ? ~last_grant : req1_valid;
        can_accept = state == EMPTY || resp_ready;
        req0_ready = rst_n && can_accept && !grant;
        req1_ready = rst_n && can_accept && grant;
        xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        state_nxt  = xfer ? FULL : (state == FULL && resp_ready) ? EMPTY : state;
        resp_valid = state == FULL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            last_grant  <= 1'b1;
            resp_result <= 32'b0;
            resp_zero   <= 1'b0;
            resp_id     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                last_grant  <= grant;
                resp_result <= alu_result;
                resp_zero   <= alu_zero;
                resp_id     <= grant;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter.
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
    logic [3:0]  req0_op, req1_op;
    logic        resp_valid, resp_ready, resp_zero, resp_id;
    logic [31:0] resp_result;
    int checks = 0;
    int failures = 0;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_src1(req0_src1), .req0_src2(req0_src2),
        .req0_op(req0_op), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_src1(req1_src1), .req1_src2(req1_src2),
        .req1_op(req1_op), .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_zero(resp_zero), .resp_id(resp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        req0_valid = v; req0_src1 = a; req0_src2 = b; req0_op = op;
    endtask

    task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        req1_valid = v; req1_src1 = a; req1_src2 = b; req1_op = op;
    endtask

    task automatic resp(input string tag, input logic v, input logic [31:0] r, input logic z, input logic id);
        chk({tag, "_valid"}, resp_valid, v);
        chk({tag, "_result"}, resp_result, r);
        chk({tag, "_zero"}, resp_zero, z);
        chk({tag, "_id"}, resp_id, id);
    endtask

    initial begin
        rst_n = 1'b0;
        resp_ready = 1'b1;
        set0(1'b1, 32'd5, 32'd7, 4'b0010);
        set1(1'b0, 32'd0, 32'd0, 4'b0000);
        #3;
        resp("rst", 1'b0, 32'd0, 1'b0, 1'b0);
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_ready1", req1_ready, 1'b0);

        // ADD 5+7 from req0 alone
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("add_ready0", req0_ready, 1'b1);
        chk("add_ready1", req1_ready, 1'b0);
        @(negedge clk);
        set0(1'b0, 32'd0, 32'd0, 4'b0000);
        resp("add", 1'b1, 32'd12, 1'b0, 1'b0);

        // both valid: last_grant is 0 after the ADD, so grants run 1,0,1,0
        set0(1'b1, 32'd1, 32'd1, 4'b0010);
        set1(1'b1, 32'h0000_00F0, 32'h0000_000F, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready1", req1_ready, (i % 2 == 0));
            chk("rr_ready0", req0_ready, (i % 2 != 0));
            @(negedge clk);
            resp("rr", 1'b1, (i % 2 == 0) ? 32'hFF : 32'd2, 1'b0, (i % 2 == 0));
        end
        set0(1'b0, 32'd0, 32'd0, 4'b0000);
        set1(1'b0, 32'd0, 32'd0, 4'b0000);
        @(negedge clk);
        chk("drain_valid", resp_valid, 1'b0);

        // SUB 9-9 from req1, then back-pressure for 3 cycles
        set1(1'b1, 32'd9, 32'd9, 4'b0110);
        resp_ready = 1'b0;
        #1;
        chk("sub_ready1", req1_ready, 1'b1);
        @(negedge clk);
        set0(1'b1, 32'h0000_00FF, 32'h0000_000F, 4'b0000);
        set1(1'b1, 32'd100, 32'd1, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            #1;
            resp("hold", 1'b1, 32'd0, 1'b1, 1'b1);
            chk("hold_ready0", req0_ready, 1'b0);
            chk("hold_ready1", req1_ready, 1'b0);
            @(negedge clk);
        end
        // release with a same-cycle transfer; last_grant=1 so req0 wins the tie
        resp_ready = 1'b1;
        #1;
        chk("rel_ready0", req0_ready, 1'b1);
        @(negedge clk);
        resp("rel", 1'b1, 32'h0000_000F, 1'b0, 1'b0);

        set1(1'b0, 32'd0, 32'd0, 4'b0000);
        set0(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0111);
        @(negedge clk);
        resp("slt", 1'b1, 32'd1, 1'b0, 1'b0);
        set0(1'b1, 32'd1, 32'hFFFF_FFFF, 4'b0111);
        @(negedge clk);
        resp("slt_neg", 1'b1, 32'd0, 1'b1, 1'b0);
        set0(1'b1, 32'd0, 32'd1, 4'b0110);
        @(negedge clk);
        resp("sub_wrap", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        set0(1'b1, 32'h0F0F_0000, 32'h0000_00F0, 4'b1100);
        @(negedge clk);
        resp("nor", 1'b1, 32'hF0F0_FF0F, 1'b0, 1'b0);
        set0(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0010);
        @(negedge clk);
        resp("add_wrap", 1'b1, 32'd0, 1'b1, 1'b0);
        set0(1'b1, 32'd5, 32'd3, 4'b0011);
        @(negedge clk);
        resp("bad_op", 1'b1, 32'd0, 1'b1, 1'b0);

        // async reset while FULL, between clock edges
        set0(1'b0, 32'd0, 32'd0, 4'b0000);
        resp_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", resp_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        resp("async_rst", 1'b0, 32'd0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        resp_ready = 1'b1;
        set0(1'b1, 32'd1, 32'd2, 4'b0010);
        set1(1'b1, 32'd10, 32'd20, 4'b0010);
        #1;
        chk("tie_ready0", req0_ready, 1'b1);
        chk("tie_ready1", req1_ready, 1'b0);
        @(negedge clk);
        resp("tie", 1'b1, 32'd3, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
